// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_stage
// Brief  : Registered RV32 ALU execute stage with valid/ready handshake.
//          Define ALU_SERIAL_SHIFT_EN for a 1-bit-per-cycle serial shifter.
// Rev    : 1.0  initial release
// ============================================================================
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        zero,
  output logic        busy
);

  localparam logic [3:0] c_op_add  = 4'b0000;
  localparam logic [3:0] c_op_sub  = 4'b1000;
  localparam logic [3:0] c_op_sll  = 4'b0001;
  localparam logic [3:0] c_op_slt  = 4'b0010;
  localparam logic [3:0] c_op_sltu = 4'b0011;
  localparam logic [3:0] c_op_xor  = 4'b0100;
  localparam logic [3:0] c_op_srl  = 4'b0101;
  localparam logic [3:0] c_op_sra  = 4'b1101;
  localparam logic [3:0] c_op_or   = 4'b0110;
  localparam logic [3:0] c_op_and  = 4'b0111;

  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_zero;
  logic        r_out_valid;

  logic [31:0] w_alu;
  logic        w_slot_free;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_val;
  logic [4:0]  w_load_rd;

  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      c_op_add:  w_alu = op_a + op_b;
      c_op_sub:  w_alu = op_a - op_b;
      c_op_sll:  w_alu = op_a << op_b[4:0];
      c_op_slt:  w_alu = {31'd0, ($signed(op_a) < $signed(op_b))};
      c_op_sltu: w_alu = {31'd0, (op_a < op_b)};
      c_op_xor:  w_alu = op_a ^ op_b;
      c_op_srl:  w_alu = op_a >> op_b[4:0];
      c_op_sra:  w_alu = $unsigned($signed(op_a) >>> op_b[4:0]);
      c_op_or:   w_alu = op_a | op_b;
      c_op_and:  w_alu = op_a & op_b;
      default:   w_alu = '0;
    endcase
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [1:0]  r_sh_op;
  logic [4:0]  r_sh_rd;
  logic        w_is_shift;
  logic        w_start;
  logic        w_shift_done;
  logic [31:0] w_acc_next;
  logic [31:0] w_shift_val;

  assign w_is_shift = (alu_ctrl == c_op_sll) || (alu_ctrl == c_op_srl) ||
                      (alu_ctrl == c_op_sra);
  assign w_start    = w_accept && w_is_shift && (op_b[4:0] != 5'd0);

  // r_sh_op: 00 = SLL, 01 = SRL, 11 = SRA (alu_ctrl bits 3 and 2)
  always_comb begin
    w_acc_next = r_acc;
    case (r_sh_op)
      2'b00:   w_acc_next = {r_acc[30:0], 1'b0};
      2'b01:   w_acc_next = {1'b0, r_acc[31:1]};
      default: w_acc_next = {r_acc[31], r_acc[31:1]};
    endcase
  end

  // The final step either loads directly (count 1) or waits parked at count 0.
  assign w_shift_done = (r_state == c_st_shift) && (r_cnt <= 5'd1) && w_slot_free;
  assign w_shift_val  = (r_cnt == 5'd0) ? r_acc : w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sh_op <= '0;
      r_sh_rd <= '0;
    end else if (flush) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_state <= c_st_shift;
      r_cnt   <= op_b[4:0];
      r_acc   <= op_a;
      r_sh_op <= {alu_ctrl[3], alu_ctrl[2]};
      r_sh_rd <= rd_in;
    end else if (r_state == c_st_shift) begin
      if (r_cnt != 5'd0) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_shift_done) begin
        r_state <= c_st_idle;
      end
    end
  end

  assign in_ready   = (r_state == c_st_idle) && w_slot_free && !flush;
  assign busy       = (r_state == c_st_shift);
  assign w_load     = (w_accept && !w_start) || w_shift_done;
  assign w_load_val = w_shift_done ? w_shift_val : w_alu;
  assign w_load_rd  = w_shift_done ? r_sh_rd : rd_in;
`else
  assign in_ready   = w_slot_free && !flush;
  assign busy       = 1'b0;
  assign w_load     = w_accept;
  assign w_load_val = w_alu;
  assign w_load_rd  = rd_in;
`endif

  // Flush wins over any load or transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_zero      <= 1'b1;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_val;
      r_rd        <= w_load_rd;
      r_zero      <= (w_load_val == 32'd0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_exec_stage
// Brief  : Scoreboard bench for alu_exec_stage; expected results are queued
//          at issue and matched (value, tag, zero, cycle) at each transfer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        zero;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A transfer happens at the next rising edge when out_valid && out_ready && !flush.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got result=%h rd=%0d at cycle %0d, required no output",
                 result, rd_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || rd_out !== mon_e.rd || zero !== mon_e.z || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL scoreboard: got result=%h rd=%0d zero=%b cycle=%0d, required result=%h rd=%0d zero=%b cycle=%0d",
                   result, rd_out, zero, cyc, mon_e.res, mon_e.rd, mon_e.z, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0; rd_in = '0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h, required 0", result); end
    vectors++;
    if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b, required 1", zero); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ctl [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] r [6];
    ctl = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0110, 4'b0111};
    a   = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00F00000, 32'hFFFF0000};
    b   = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h0000000F, 32'h12345678};
    r   = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'h00F0000F, 32'h12340000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_ctrl = ctl[i]; op_a = a[i]; op_b = b[i]; rd_in = 5'(i + 1); in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready); end
      sb.push_back('{r[i], 5'(i + 1), (r[i] == 32'd0), cyc + 1});
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_backpressure;
    int c0;
    out_ready = 1'b1;
    alu_ctrl = 4'b0100; op_a = 32'h0000F0F0; op_b = 32'h00000FF0; rd_in = 5'd7; in_valid = 1'b1;
    c0 = cyc;
    sb.push_back('{32'h0000FF00, 5'd7, 1'b0, c0 + 4});
    tick;
    alu_ctrl = 4'b0111; op_a = 32'h000000FF; op_b = 32'h0000000F; rd_in = 5'd9; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || result !== 32'h0000FF00 || rd_out !== 5'd7) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b result=%h rd=%0d, required valid=1 result=0000ff00 rd=7",
                 k, out_valid, result, rd_out);
      end
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", k, in_ready); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
    sb.push_back('{32'h0000000F, 5'd9, 1'b0, cyc + 1});
    tick;
    in_valid = 1'b0;
    tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    alu_ctrl = 4'b1010; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd21; in_valid = 1'b1;
    sb.push_back('{32'd0, 5'd21, 1'b1, cyc + 1});
    tick;
    alu_ctrl = 4'b1111; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd22;
    sb.push_back('{32'd0, 5'd22, 1'b1, cyc + 1});
    #1;
    vectors++;
    if (result !== 32'd0 || zero !== 1'b1 || rd_out !== 5'd21) begin
      miscompares++;
      $display("FAIL illegal_direct: got result=%h zero=%b rd=%0d, required result=0 zero=1 rd=21",
               result, zero, rd_out);
    end
    tick;
    in_valid = 1'b0;
    tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL illegal_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

`ifdef ALU_SERIAL_SHIFT_EN
  task automatic test_shift;
    int n;
    out_ready = 1'b1;
    alu_ctrl = 4'b1101; op_a = 32'h80000000; op_b = 32'd4; rd_in = 5'd3; in_valid = 1'b1;
    n = cyc;
    sb.push_back('{32'hF8000000, 5'd3, 1'b0, n + 5});
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL shift_busy[N+%0d]: got busy=%b in_ready=%b, required busy=1 in_ready=0", k, busy, in_ready);
      end
      tick;
    end
    alu_ctrl = 4'b0001; op_a = 32'h00000123; op_b = 32'hFFFFFFE0; rd_in = 5'd4; in_valid = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL shift_done_busy: got %b, required 0", busy); end
    sb.push_back('{32'h00000123, 5'd4, 1'b0, cyc + 1});
    tick;
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL shift0_busy: got %b, required 0", busy); end
    tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL shift_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_flush_shift;
    out_ready = 1'b1;
    alu_ctrl = 4'b0001; op_a = 32'd1; op_b = 32'd31; rd_in = 5'd11; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL fsh_busy_before: got %b, required 1", busy); end
    flush = 1'b1; alu_ctrl = 4'b0000; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd12; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fsh_in_ready: got %b, required 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fsh_after: got busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
    repeat (30) tick;
  endtask

  task automatic test_rst_shift;
    out_ready = 1'b1;
    alu_ctrl = 4'b0101; op_a = 32'h000000F0; op_b = 32'd10; rd_in = 5'd13; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_shift: got busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
    repeat (15) tick;
  endtask
`else
  task automatic test_shift;
    logic [3:0]  ctl [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] r [3];
    ctl = '{4'b1101, 4'b0001, 4'b0101};
    a   = '{32'h80000000, 32'h00000001, 32'h80000000};
    b   = '{32'd4, 32'd31, 32'h00000021};
    r   = '{32'hF8000000, 32'h80000000, 32'h40000000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = ctl[i]; op_a = a[i]; op_b = b[i]; rd_in = 5'(i + 16); in_valid = 1'b1;
      sb.push_back('{r[i], 5'(i + 16), 1'b0, cyc + 1});
      #1;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL shift_busy[%0d]: got %b, required 0", i, busy); end
      tick;
    end
    in_valid = 1'b0;
    tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL shift_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask
`endif

  task automatic test_flush_output;
    out_ready = 1'b1;
    alu_ctrl = 4'b0000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd8; in_valid = 1'b1;
    tick;
    out_ready = 1'b0; flush = 1'b1; alu_ctrl = 4'b1000; rd_in = 5'd10;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fout_in_ready: got %b, required 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fout_valid: got %b, required 0", out_valid); end
    repeat (3) tick;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL fout_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_shift();
    test_flush_output();
`ifdef ALU_SERIAL_SHIFT_EN
    test_flush_shift();
    test_rst_shift();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
